mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised MEM stage of the pipelined RV32I/RV64I core, replacing the single-cycle word-only memory stage. It performs byte/half/word (and double when XLEN=64) loads and stores with lane alignment and sign/zero extension. It drives an external data-memory port with a req/ack handshake and variable wait states, stalls the upstream pipeline while a transfer is outstanding, and registers results into the MEM/WB stage. Misaligned accesses, illegal widths and bus timeouts are reported as faults instead of reaching memory.

## Interface
- XLEN, 32, datapath width; 32 or 64 only
- TIMEOUT, 0, maximum WAIT cycles before bus-error fault; 0 disables the timeout
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX/MEM holds a live instruction
- in_alu_out  in  XLEN  effective address or ALU result
- in_wdata  in  XLEN  store data, unaligned (LSBs)
- in_rd  in  5  destination register
- in_mem_read, in_mem_write  in  1 each  load / store
- in_funct3  in  3  access width/sign, RISC-V encoding
- in_regwrite_en  in  1  writeback enable
- in_wb_sel  in  2  writeback source select
- mem_stall  out  1  hold EX/MEM and earlier stages this cycle
- dmem_req  out  1  bus request; held until ack
- dmem_we  out  1  write request
- dmem_be  out  XLEN/8  byte enables
- dmem_addr  out  XLEN  address, aligned down to XLEN/8
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_ack  in  1  transfer complete; dmem_rdata valid the same cycle
- dmem_rdata  in  XLEN  raw read word
- out_valid, out_rd, out_regwrite_en, out_wb_sel, out_alu_out, out_load_data  out  MEM/WB register contents
- out_fault  out  1  MEM/WB carries a faulting instruction
- out_cause  out  2  0 none, 1 misaligned, 2 illegal width, 3 bus timeout

## Operation
- States: IDLE, WAIT. A memory op is in_valid & (in_mem_read | in_mem_write).
- IDLE, non-memory op: pass through to MEM/WB next edge; mem_stall=0.
- IDLE, legal aligned memory op: dmem_req=1 combinationally in the same cycle.
  - ack in the same cycle: zero-wait; capture into MEM/WB; stay IDLE.
  - no ack: mem_stall=1; go to WAIT; MEM/WB loads a bubble (out_valid=0, out_regwrite_en=0).
- WAIT: dmem_req, addr, we, be and wdata are held stable. mem_stall = !dmem_ack.
  - On ack: capture, go to IDLE.
  - TIMEOUT>0 and counter reaches TIMEOUT: drop req, write a fault entry with cause 3, go to IDLE.
- Width (funct3): 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU. Codes 011 and 110 are legal only when XLEN=64. Anything else is illegal width (cause 2).
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
- Fault entries (cause 1/2/3): no bus request issued (cause 1/2), out_valid=1, out_fault=1, out_regwrite_en forced to 0.
- Stores: dmem_be = width mask << offset (offset = addr mod XLEN/8). wdata is replicated across all lanes.
- Loads: shift rdata right by offset×8, then sign- or zero-extend to XLEN. A store writes 0 to out_load_data.
- Simultaneous in_valid=0 with memory flags set: no request, bubble.

## Timing
- Reset values: all out_* 0, dmem_req 0, mem_stall 0, state IDLE, timeout counter 0.
- Reset asserted in WAIT: transaction abandoned, no writeback, dmem_req low immediately. The memory tolerates abandoned requests.
- Latency: 1 cycle for zero-wait and non-memory ops; 1+N cycles for N wait states. Load data appears at out_load_data on the edge after ack.
- Upstream keeps in_* stable while mem_stall=1. The block does not re-sample in_* in WAIT.
- Timeout counter clears on entering WAIT. A fault is raised in the cycle count==TIMEOUT; an ack arriving in that same cycle wins.

## Structure
- Package mem_pkg holds:
  - funct3 width constants
  - cause codes
  - state enum
- Sub-module lsu_align (combinational) owns byte-enable generation, store lane replication, load extract/extend, and misalign/illegal detection.
- Top level holds the FSM, timeout counter and MEM/WB register.

## Test plan
- SW 0xDEADBEEF @0x100, ack same cycle -> be=1111, mem_stall never 1. Then LW @0x100 -> out_load_data=0xDEADBEEF one cycle later.
- SB 0xA5 @0x103 -> be=1000, wdata=0xA5A5A5A5. LB @0x103 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- LH @0x102 with ack after 3 wait cycles -> mem_stall high for exactly 3 cycles, 3 bubbles, signed halfword written once.
- LW @0x101 -> no dmem_req, out_fault=1, cause=1, out_regwrite_en=0. Funct3=011 with XLEN=32 -> cause=2.
- TIMEOUT=4 with no ack -> req dropped after 4 WAIT cycles, cause=3. rst pulsed mid-WAIT -> all outputs 0, next instruction proceeds normally.
- XLEN=64: SD then LD @0x8 round-trip 64-bit value. LWU of 0x80000000 -> 0x0000000080000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the load/store MEM stage.
// Width codes follow the RISC-V funct3 encoding.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    function automatic logic width_legal(input logic [2:0] f3,
                                         input int xlen);
        logic ok;
        ok = 1'b0;
        unique case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = (xlen == 64);
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication,
// load extract/extend and alignment/width checks.
module lsu_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    input  logic [2:0]        funct3,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_rep,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              illegal
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [OW-1:0]   off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [NB-1:0]   mask;
    logic            sbit;

    assign off = addr[OW-1:0];

    always_comb begin
        illegal    = !width_legal(funct3, XLEN);
        misaligned = 1'b0;
        mask       = '0;
        keep       = '0;
        sbit       = 1'b0;
        wdata_rep  = wdata;
        shifted    = rdata >> {off, 3'b000};
        unique case (funct3[1:0])
            2'd0: begin
                mask      = NB'(8'h01);
                keep      = XLEN'(64'hFF);
                sbit      = shifted[7];
                wdata_rep = {NB{wdata[7:0]}};
            end
            2'd1: begin
                mask       = NB'(8'h03);
                keep       = XLEN'(64'hFFFF);
                sbit       = shifted[15];
                wdata_rep  = {(NB/2){wdata[15:0]}};
                misaligned = addr[0];
            end
            2'd2: begin
                mask       = NB'(8'h0F);
                keep       = XLEN'(64'hFFFF_FFFF);
                sbit       = shifted[31];
                wdata_rep  = {(NB/4){wdata[31:0]}};
                misaligned = |addr[1:0];
            end
            default: begin
                mask       = NB'(8'hFF);
                keep       = '1;
                sbit       = shifted[XLEN-1];
                wdata_rep  = wdata;
                misaligned = |addr[2:0];
            end
        endcase
        be = mask << off;
        // funct3[2] selects zero extension
        load_data = (shifted & keep)
                  | (~keep & {XLEN{sbit & ~funct3[2]}});
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: data-memory handshake FSM, timeout and MEM/WB register.
// Requests stay stable in WAIT from a snapshot taken at issue.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic              in_regwrite_en,
    input  logic [1:0]        in_wb_sel,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic              out_regwrite_en,
    output logic [1:0]        out_wb_sel,
    output logic [XLEN-1:0]   out_alu_out,
    output logic [XLEN-1:0]   out_load_data,
    output logic              out_fault,
    output logic [1:0]        out_cause
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [XLEN-1:0] h_addr_q, h_addr_d;
    logic [XLEN-1:0] h_wdata_q, h_wdata_d;
    logic [2:0]      h_funct3_q, h_funct3_d;
    logic [4:0]      h_rd_q, h_rd_d;
    logic            h_we_q, h_we_d;
    logic            h_rwe_q, h_rwe_d;
    logic [1:0]      h_wb_sel_q, h_wb_sel_d;

    logic            ov_q, ov_d;
    logic [4:0]      ord_q, ord_d;
    logic            orwe_q, orwe_d;
    logic [1:0]      owbs_q, owbs_d;
    logic [XLEN-1:0] oalu_q, oalu_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            oflt_q, oflt_d;
    logic [1:0]      ocause_q, ocause_d;

    logic            in_wait;
    logic [XLEN-1:0] cur_addr, cur_wdata;
    logic [2:0]      cur_funct3;
    logic [4:0]      cur_rd;
    logic            cur_we, cur_rwe;
    logic [1:0]      cur_wb_sel;

    logic [NB-1:0]   al_be;
    logic [XLEN-1:0] al_wdata, al_load;
    logic            al_mis, al_ill;

    logic            mem_op, tmo;
    logic            req, stall;
    logic            entry, capture, fault;
    logic [1:0]      cause;

    assign in_wait    = (state_q == ST_WAIT);
    assign cur_addr   = in_wait ? h_addr_q   : in_alu_out;
    assign cur_wdata  = in_wait ? h_wdata_q  : in_wdata;
    assign cur_funct3 = in_wait ? h_funct3_q : in_funct3;
    assign cur_rd     = in_wait ? h_rd_q     : in_rd;
    assign cur_we     = in_wait ? h_we_q     : in_mem_write;
    assign cur_rwe    = in_wait ? h_rwe_q    : in_regwrite_en;
    assign cur_wb_sel = in_wait ? h_wb_sel_q : in_wb_sel;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr       (cur_addr),
        .wdata      (cur_wdata),
        .rdata      (dmem_rdata),
        .funct3     (cur_funct3),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis),
        .illegal    (al_ill)
    );

    assign mem_op = in_valid & (in_mem_read | in_mem_write);
    assign tmo    = (TIMEOUT > 0) && in_wait && !dmem_ack
                 && (cnt_q == 32'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_addr_d   = h_addr_q;
        h_wdata_d  = h_wdata_q;
        h_funct3_d = h_funct3_q;
        h_rd_d     = h_rd_q;
        h_we_d     = h_we_q;
        h_rwe_d    = h_rwe_q;
        h_wb_sel_d = h_wb_sel_q;
        req        = 1'b0;
        stall      = 1'b0;
        entry      = 1'b0;
        capture    = 1'b0;
        fault      = 1'b0;
        cause      = CAUSE_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !mem_op) begin
                    entry = 1'b1;
                end else if (mem_op && al_ill) begin
                    entry = 1'b1;
                    fault = 1'b1;
                    cause = CAUSE_ILLEGAL;
                end else if (mem_op && al_mis) begin
                    entry = 1'b1;
                    fault = 1'b1;
                    cause = CAUSE_MISALIGN;
                end else if (mem_op) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        entry   = 1'b1;
                        capture = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_d    = ST_WAIT;
                        cnt_d      = '0;
                        h_addr_d   = in_alu_out;
                        h_wdata_d  = in_wdata;
                        h_funct3_d = in_funct3;
                        h_rd_d     = in_rd;
                        h_we_d     = in_mem_write;
                        h_rwe_d    = in_regwrite_en;
                        h_wb_sel_d = in_wb_sel;
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    entry   = 1'b1;
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    // faulting op retires, so upstream may advance
                    entry   = 1'b1;
                    fault   = 1'b1;
                    cause   = CAUSE_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ov_d     = entry;
        ord_d    = entry ? cur_rd : 5'd0;
        owbs_d   = entry ? cur_wb_sel : 2'd0;
        oalu_d   = entry ? cur_addr : '0;
        orwe_d   = entry & cur_rwe & ~fault;
        oflt_d   = fault;
        ocause_d = cause;
        old_d    = (capture && !cur_we) ? al_load : '0;
    end

    assign dmem_req   = req & ~rst;
    assign mem_stall  = stall & ~rst;
    assign dmem_we    = dmem_req & cur_we;
    assign dmem_be    = dmem_req ? al_be : '0;
    assign dmem_addr  = {cur_addr[XLEN-1:OW], {OW{1'b0}}};
    assign dmem_wdata = al_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            h_addr_q   <= '0;
            h_wdata_q  <= '0;
            h_funct3_q <= '0;
            h_rd_q     <= '0;
            h_we_q     <= 1'b0;
            h_rwe_q    <= 1'b0;
            h_wb_sel_q <= '0;
            ov_q       <= 1'b0;
            ord_q      <= '0;
            orwe_q     <= 1'b0;
            owbs_q     <= '0;
            oalu_q     <= '0;
            old_q      <= '0;
            oflt_q     <= 1'b0;
            ocause_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_addr_q   <= h_addr_d;
            h_wdata_q  <= h_wdata_d;
            h_funct3_q <= h_funct3_d;
            h_rd_q     <= h_rd_d;
            h_we_q     <= h_we_d;
            h_rwe_q    <= h_rwe_d;
            h_wb_sel_q <= h_wb_sel_d;
            ov_q       <= ov_d;
            ord_q      <= ord_d;
            orwe_q     <= orwe_d;
            owbs_q     <= owbs_d;
            oalu_q     <= oalu_d;
            old_q      <= old_d;
            oflt_q     <= oflt_d;
            ocause_q   <= ocause_d;
        end
    end

    assign out_valid       = ov_q;
    assign out_rd          = ord_q;
    assign out_regwrite_en = orwe_q;
    assign out_wb_sel      = owbs_q;
    assign out_alu_out     = oalu_q;
    assign out_load_data   = old_q;
    assign out_fault       = oflt_q;
    assign out_cause       = ocause_q;

endmodule
